// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants and state types for the paddle controller.
package ps2_pkg;

  localparam logic [7:0] BRK = 8'hF0;
  localparam logic [7:0] EXT = 8'hE0;
  localparam logic [7:0] W   = 8'h1D;
  localparam logic [7:0] S   = 8'h1B;
  localparam logic [7:0] UP  = 8'h75;
  localparam logic [7:0] DN  = 8'h72;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    D_IDLE    = 2'd0,
    D_EXT     = 2'd1,
    D_BRK     = 2'd2,
    D_EXT_BRK = 2'd3
  } dec_state_e;

endpackage

// File: rtl/ps2_paddle_ctrl_if.sv
// Output bundle of the paddle controller: decoded key stream, paddle commands, FSM debug state.
interface ps2_paddle_ctrl_if;
  import ps2_pkg::*;

  // key_valid is a single-cycle strobe with no back-pressure: key_code is
  // meaningful in the cycle key_valid is high and holds until the next strobe.
  logic [7:0] key_code;
  logic       key_valid;
  logic       frame_err;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  rx_state_e  rx_state;
  dec_state_e dec_state;

  modport master (
    output key_code, key_valid, frame_err,
    output p1_up, p1_down, p2_up, p2_down,
    output rx_state, dec_state
  );

  modport slave (
    input key_code, key_valid, frame_err,
    input p1_up, p1_down, p2_up, p2_down,
    input rx_state, dec_state
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizer, clock fall detect, frame FSM and idle timeout.
// Odd-parity enforcement is compiled in with PS2_PARITY_CHECK_EN.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       err_o,
  output rx_state_e  state_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic [SYNC_STAGES:0]   clk_shift;
  logic [SYNC_STAGES:0]   dat_shift;
  logic                   clk_s;
  logic                   dat_s;
  logic                   clk_prev_q;
  logic                   fall;
  logic                   par_ok;

  rx_state_e              state_q;
  logic [7:0]             shift_q;
  logic [2:0]             bit_cnt_q;
  logic [TW-1:0]          tmo_q;
  logic [7:0]             byte_q;
  logic                   byte_valid_q;
  logic                   err_q;

  assign clk_shift = {clk_sync_q, ps2_clk_i};
  assign dat_shift = {dat_sync_q, ps2_dat_i};
  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign dat_s     = dat_sync_q[SYNC_STAGES-1];
  assign fall      = clk_prev_q & ~clk_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= clk_shift[SYNC_STAGES-1:0];
      dat_sync_q <= dat_shift[SYNC_STAGES-1:0];
      clk_prev_q <= clk_s;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_q;
  assign par_ok = ^{shift_q, par_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      par_q <= 1'b0;
    else if (fall && state_q == PARITY) par_q <= dat_s;
  end
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      tmo_q        <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      err_q        <= 1'b0;
      if (fall) begin
        tmo_q <= '0;
        case (state_q)
          IDLE: begin
            if (!dat_s) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {dat_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: state_q <= STOP;
          STOP: begin
            state_q <= IDLE;
            if (dat_s && par_ok) begin
              byte_q       <= shift_q;
              byte_valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        // Abort on the TIMEOUT_CYCLES-th quiet cycle; the counter never wraps.
        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_q <= IDLE;
          err_q   <= 1'b1;
          tmo_q   <= '0;
        end else if (tmo_q != TW'(TIMEOUT_CYCLES)) begin
          tmo_q <= tmo_q + TW'(1);
        end
      end
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign err_o        = err_q;
  assign state_o      = state_q;

endmodule

// File: rtl/ps2_paddle_ctrl.sv
// PS/2 keyboard to two-player paddle commands (W/S and arrow up/down).
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_paddle_ctrl
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              PS2_CLK_in,
  input  logic              PS2_DAT_in,
  ps2_paddle_ctrl_if.master bus
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  rx_state_e  rx_state;

  dec_state_e dec_q;
  logic [7:0] key_code_q;
  logic       key_valid_q;
  logic       frame_err_q;
  logic       p1_up_held_q;
  logic       p1_dn_held_q;
  logic       p2_up_held_q;
  logic       p2_dn_held_q;
  logic       is_make;
  logic       is_ext;

  ps2_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i        (clock),
    .rst_ni       (reset_n),
    .ps2_clk_i    (PS2_CLK_in),
    .ps2_dat_i    (PS2_DAT_in),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .err_o        (rx_err),
    .state_o      (rx_state)
  );

  assign is_make = (dec_q == D_IDLE) || (dec_q == D_EXT);
  assign is_ext  = (dec_q == D_EXT)  || (dec_q == D_EXT_BRK);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dec_q        <= D_IDLE;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      p1_up_held_q <= 1'b0;
      p1_dn_held_q <= 1'b0;
      p2_up_held_q <= 1'b0;
      p2_dn_held_q <= 1'b0;
    end else begin
      key_valid_q <= rx_valid;
      frame_err_q <= rx_err;
      if (rx_err) begin
        // A broken frame drops any pending prefix but keeps held keys.
        dec_q <= D_IDLE;
      end else if (rx_valid) begin
        key_code_q <= rx_byte;
        if (rx_byte == EXT && dec_q == D_IDLE) begin
          dec_q <= D_EXT;
        end else if (rx_byte == BRK && dec_q == D_IDLE) begin
          dec_q <= D_BRK;
        end else if (rx_byte == BRK && dec_q == D_EXT) begin
          dec_q <= D_EXT_BRK;
        end else begin
          dec_q <= D_IDLE;
          if (!is_ext && rx_byte == W)  p1_up_held_q <= is_make;
          if (!is_ext && rx_byte == S)  p1_dn_held_q <= is_make;
          if (is_ext  && rx_byte == UP) p2_up_held_q <= is_make;
          if (is_ext  && rx_byte == DN) p2_dn_held_q <= is_make;
        end
      end
    end
  end

  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.p1_up     = p1_up_held_q & ~p1_dn_held_q;
  assign bus.p1_down   = p1_dn_held_q & ~p1_up_held_q;
  assign bus.p2_up     = p2_up_held_q & ~p2_dn_held_q;
  assign bus.p2_down   = p2_dn_held_q & ~p2_up_held_q;
  assign bus.rx_state  = rx_state;
  assign bus.dec_state = dec_q;

endmodule

// File: tb/tb_ps2_paddle_ctrl.sv
// Directed bench for ps2_paddle_ctrl: vector table of frames plus timeout and reset sequences.
module tb_ps2_paddle_ctrl;
  import ps2_pkg::*;

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       stop_b;
    int         exp_kv;
    int         exp_fe;
    logic [7:0] exp_code;
    logic [3:0] exp_p;   // {p1_up, p1_down, p2_up, p2_down}
  } vec_t;

  localparam int NV = 29;

  logic clock;
  logic reset_n;
  logic PS2_CLK_in;
  logic PS2_DAT_in;

  int total;
  int bad;
  int kv_cnt;
  int fe_cnt;
  int kv_long;
  logic kv_prev;
  logic [7:0] snap_code;
  logic [3:0] snap_p;

  vec_t vecs[NV];

  ps2_paddle_ctrl_if bus ();

  ps2_paddle_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .PS2_CLK_in (PS2_CLK_in),
    .PS2_DAT_in (PS2_DAT_in),
    .bus        (bus.master)
  );

  // clock / reset
  initial clock = 1'b0;
  always #10 clock = ~clock;

  function automatic logic [3:0] pads();
    return {bus.p1_up, bus.p1_down, bus.p2_up, bus.p2_down};
  endfunction

  // monitor: counts strobes and snapshots outputs in the key_valid cycle
  initial begin
    kv_cnt = 0; fe_cnt = 0; kv_long = 0; kv_prev = 1'b0;
    snap_code = '0; snap_p = '0;
  end

  always @(negedge clock) begin
    if (bus.key_valid) begin
      kv_cnt++;
      snap_code = bus.key_code;
      snap_p    = pads();
      if (kv_prev) kv_long++;
    end
    kv_prev = bus.key_valid;
    if (bus.frame_err) fe_cnt++;
  end

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // drivers
  task automatic send_bit(input logic b);
    @(negedge clock);
    PS2_DAT_in = b;
    repeat (10) @(negedge clock);
    PS2_CLK_in = 1'b0;
    repeat (10) @(negedge clock);
    PS2_CLK_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_b);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop_b);
    PS2_DAT_in = 1'b1;
    repeat (40) @(negedge clock);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_key_code"},  {24'd0, bus.key_code}, 32'd0);
    chk({tag, "_key_valid"}, {31'd0, bus.key_valid}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, bus.frame_err}, 32'd0);
    chk({tag, "_pads"},      {28'd0, pads()}, 32'd0);
    chk({tag, "_rx_state"},  {30'd0, bus.rx_state}, {30'd0, IDLE});
    chk({tag, "_dec_state"}, {30'd0, bus.dec_state}, {30'd0, D_IDLE});
  endtask

  initial begin
    int kv0;
    int fe0;
    int waited;
    total = 0;
    bad   = 0;

    vecs[0]  = '{8'h1D, 1'b0, 1'b1, 1, 0, 8'h1D, 4'b1000};
    vecs[1]  = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0, 4'b1000};
    vecs[2]  = '{8'h1D, 1'b0, 1'b1, 1, 0, 8'h1D, 4'b0000};
    vecs[3]  = '{8'hE0, 1'b0, 1'b1, 1, 0, 8'hE0, 4'b0000};
    vecs[4]  = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 4'b0010};
    vecs[5]  = '{8'hE0, 1'b0, 1'b1, 1, 0, 8'hE0, 4'b0010};
    vecs[6]  = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0, 4'b0010};
    vecs[7]  = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 4'b0000};
    vecs[8]  = '{8'h1D, 1'b0, 1'b1, 1, 0, 8'h1D, 4'b1000};
    vecs[9]  = '{8'h1B, 1'b0, 1'b1, 1, 0, 8'h1B, 4'b0000};
    vecs[10] = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0, 4'b0000};
    vecs[11] = '{8'h1B, 1'b0, 1'b1, 1, 0, 8'h1B, 4'b1000};
    vecs[12] = '{8'h1D, 1'b0, 1'b1, 1, 0, 8'h1D, 4'b1000};
    vecs[13] = '{8'h33, 1'b0, 1'b1, 1, 0, 8'h33, 4'b1000};
    vecs[14] = '{8'h1B, 1'b0, 1'b0, 0, 1, 8'h33, 4'b1000};
    vecs[15] = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 4'b1000};
    vecs[16] = '{8'hE0, 1'b0, 1'b1, 1, 0, 8'hE0, 4'b1000};
    vecs[17] = '{8'h11, 1'b0, 1'b0, 0, 1, 8'hE0, 4'b1000};
    vecs[18] = '{8'h72, 1'b0, 1'b1, 1, 0, 8'h72, 4'b1000};
    vecs[19] = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0, 4'b1000};
    vecs[20] = '{8'h1D, 1'b0, 1'b1, 1, 0, 8'h1D, 4'b0000};
`ifdef PS2_PARITY_CHECK_EN
    vecs[21] = '{8'h1B, 1'b1, 1'b1, 0, 1, 8'h1D, 4'b0000};
    vecs[22] = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0, 4'b0000};
`else
    vecs[21] = '{8'h1B, 1'b1, 1'b1, 1, 0, 8'h1B, 4'b0100};
    vecs[22] = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0, 4'b0100};
`endif
    vecs[23] = '{8'h1B, 1'b0, 1'b1, 1, 0, 8'h1B, 4'b0000};
    vecs[24] = '{8'hE0, 1'b0, 1'b1, 1, 0, 8'hE0, 4'b0000};
    vecs[25] = '{8'h72, 1'b0, 1'b1, 1, 0, 8'h72, 4'b0001};
    vecs[26] = '{8'hE0, 1'b0, 1'b1, 1, 0, 8'hE0, 4'b0001};
    vecs[27] = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0, 4'b0001};
    vecs[28] = '{8'h72, 1'b0, 1'b1, 1, 0, 8'h72, 4'b0000};

    reset_n    = 1'b0;
    PS2_CLK_in = 1'b1;
    PS2_DAT_in = 1'b1;
    repeat (5) @(negedge clock);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    repeat (20) @(negedge clock);

    // table-driven frames
    for (int i = 0; i < NV; i++) begin
      kv0 = kv_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop_b);
      chk($sformatf("v%0d_kv", i), kv_cnt - kv0, vecs[i].exp_kv);
      chk($sformatf("v%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
      chk($sformatf("v%0d_code", i), {24'd0, bus.key_code}, {24'd0, vecs[i].exp_code});
      chk($sformatf("v%0d_pads", i), {28'd0, pads()}, {28'd0, vecs[i].exp_p});
      if (vecs[i].exp_kv != 0) begin
        chk($sformatf("v%0d_snap_code", i), {24'd0, snap_code}, {24'd0, vecs[i].exp_code});
        chk($sformatf("v%0d_snap_pads", i), {28'd0, snap_p}, {28'd0, vecs[i].exp_p});
      end
    end

    // timeout: E0 prefix, then a frame stalls after 4 data bits
    send_frame(8'hE0, 1'b0, 1'b1);
    chk("tmo_prefix_dec", {30'd0, bus.dec_state}, {30'd0, D_EXT});
    fe0 = fe_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    PS2_DAT_in = 1'b1;
    repeat (49900) @(negedge clock);
    chk("tmo_not_early", fe_cnt - fe0, 0);
    waited = 0;
    while (fe_cnt == fe0 && waited < 400) begin
      @(negedge clock);
      waited++;
    end
    chk("tmo_frame_err", fe_cnt - fe0, 1);
    chk("tmo_dec_idle", {30'd0, bus.dec_state}, {30'd0, D_IDLE});
    chk("tmo_rx_idle", {30'd0, bus.rx_state}, {30'd0, IDLE});
    kv0 = kv_cnt;
    send_frame(8'h75, 1'b0, 1'b1);
    chk("tmo_after_kv", kv_cnt - kv0, 1);
    chk("tmo_after_code", {24'd0, bus.key_code}, 32'h75);
    chk("tmo_after_pads", {28'd0, pads()}, 32'd0);

    // reset mid-frame with p1_down held
    send_frame(8'h1B, 1'b0, 1'b1);
    chk("rst_pre_pads", {28'd0, pads()}, 32'b0100);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clock);
    PS2_CLK_in = 1'b0;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_idle_outputs("rst_mid");
    PS2_CLK_in = 1'b1;
    PS2_DAT_in = 1'b1;
    repeat (5) @(negedge clock);
    fe0 = fe_cnt;
    reset_n = 1'b1;
    repeat (100) @(negedge clock);
    chk("rst_no_frame_err", fe_cnt - fe0, 0);
    kv0 = kv_cnt;
    send_frame(8'h1D, 1'b0, 1'b1);
    chk("rst_after_kv", kv_cnt - kv0, 1);
    chk("rst_after_code", {24'd0, bus.key_code}, 32'h1D);
    chk("rst_after_pads", {28'd0, pads()}, 32'b1000);

    chk("key_valid_width", kv_long, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_paddle_ctrl.md
PS2_PADDLE_CTRL -- requirements
Module: ps2_paddle_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- SYNC_STAGES, 2, synchronizer depth for PS2_CLK_in/PS2_DAT_in.
- TIMEOUT_CYCLES, 50000, idle `clock` cycles mid-frame before the receiver aborts.
REQ-002 Ports, one per line: name, direction, width, meaning:
- clock, in, 1, system clock (50 MHz). One clock only.
- reset_n, in, 1, asynchronous active-low reset.
- PS2_CLK_in, in, 1, raw PS/2 clock, asynchronous.
- PS2_DAT_in, in, 1, raw PS/2 data, asynchronous.
- key_code, out, 8, last accepted byte.
- key_valid, out, 1, 1-cycle pulse when key_code updates.
- frame_err, out, 1, 1-cycle pulse on bad frame or timeout.
- p1_up / p1_down, out, 1 each, player 1 paddle command (W / S).
- p2_up / p2_down, out, 1 each, player 2 paddle command (arrow up / arrow down).

Function
REQ-003 The block SHALL pass both PS/2 inputs through SYNC_STAGES flops on `clock` and detect PS/2 clock falling edges from the synchronized signal; no derived clocks.
REQ-004 The receiver FSM SHALL have states IDLE, DATA, PARITY, STOP and advance only on a detected falling edge.
REQ-005 In IDLE, a sampled 0 (start) SHALL enter DATA; a sampled 1 SHALL be ignored.
REQ-006 DATA SHALL shift 8 bits LSB first and then enter PARITY; PARITY SHALL capture the bit and enter STOP.
REQ-007 STOP SHALL return to IDLE. A stop bit of 1 with a passing check SHALL assert byte_valid internally for one cycle at edge cycle N.
REQ-008 A stop bit of 0 SHALL pulse frame_err at N+1 and discard the byte.
REQ-009 If the receiver is not in IDLE and TIMEOUT_CYCLES elapse with no falling edge, it SHALL return to IDLE and pulse frame_err. The counter SHALL reset on every edge and saturate, not wrap.
REQ-010 On an accepted byte at N:
- key_code SHALL equal the byte at N+1.
- key_valid SHALL be high for exactly cycle N+1.
REQ-011 The decoder FSM SHALL have states D_IDLE, D_EXT, D_BRK, D_EXT_BRK. Transitions on an accepted byte:
- 0xE0: from D_IDLE to D_EXT.
- 0xF0: from D_IDLE to D_BRK; from D_EXT to D_EXT_BRK.
- Any other byte: apply a make or break event, then go to D_IDLE.
REQ-012 Key events: a make in D_IDLE/D_EXT SHALL set the key's held flag; a break in D_BRK/D_EXT_BRK SHALL clear it. Keys:
- Non-extended: 0x1D (W) = p1 up, 0x1B (S) = p1 down.
- Extended: 0x75 = p2 up, 0x72 = p2 down.
- Unmapped codes and typematic repeats SHALL change no flag.
REQ-013 pX_up SHALL equal up_held AND NOT down_held; pX_down is symmetric. Both held SHALL give both outputs 0.
REQ-014 Held-flag changes SHALL be visible on the outputs at N+1, the same cycle as key_valid.
REQ-015 A frame_err SHALL return the decoder to D_IDLE, dropping any pending prefix. Held flags SHALL be unchanged.
REQ-016 Players SHALL be independent; an event for one player SHALL never alter the other player's flags.

Reset
REQ-017 While reset_n is low, all of the following SHALL be 0: outputs, held flags, counters, synchronizer flops (asynchronously).
REQ-018 While reset_n is low, both FSMs SHALL be in IDLE / D_IDLE.
REQ-019 A partial frame interrupted by reset SHALL be discarded with no frame_err after release.

Configuration
REQ-020 With macro PS2_PARITY_CHECK_EN defined, a byte SHALL be accepted only if data plus parity has odd parity. Otherwise the block SHALL pulse frame_err as in REQ-008.
REQ-021 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored.

Structure
REQ-022 Package ps2_pkg SHALL hold:
- scan-code constants: BRK 0xF0, EXT 0xE0, W 0x1D, S 0x1B, UP 0x75, DN 0x72;
- enum types for the receiver and decoder states.
REQ-023 Sub-module ps2_rx SHALL contain the synchronizer, edge detect, receiver FSM and timeout, and output byte, byte_valid and err. The decoder and paddle logic SHALL reside in ps2_paddle_ctrl.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Frame 0x1D with good parity -> key_code=0x1D, key_valid 1 cycle, p1_up=1; then F0 1D -> p1_up=0.
- E0 75 -> p2_up=1 and p1 outputs unchanged; E0 F0 75 -> p2_up=0.
- W held, then S make -> p1_up=0, p1_down=0; S break -> p1_up=1.
- 0x1B with bad parity (PS2_PARITY_CHECK_EN defined) -> frame_err pulse, no key_valid, flags unchanged; undefined -> p1_down=1.
- E0, then a frame stalled after 4 bits for >50000 cycles -> frame_err; next 0x75 is treated non-extended, so p2 is unchanged.
- reset_n low mid-frame with p1_down held -> all outputs 0; a clean frame after release decodes normally.
